// File: rtl/utopia_phy_rx_source_pkg.sv
// Shared constants and types for the Utopia Level 1 Rx PHY source.
package utopia_pkg;

    localparam int unsigned CELL_BYTES = 53;
    localparam int unsigned IDX_W      = 6;

    typedef logic [7:0] utopia_byte_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_BYTES - 1);

    // Read FSM encodings kept as plain constants for legacy compatibility.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/utopia_phy_rx_source_if.sv
// Utopia Level 1 Rx octet-handshake bus between PHY (master) and ATM layer (slave).
interface utopia_phy_rx_source_if;
    import utopia_pkg::*;

    utopia_byte_t Rx_data;
    logic         Rx_soc;
    logic         Rx_en;
    logic         Rx_clav;

    modport master (output Rx_data, output Rx_soc, output Rx_clav, input Rx_en);
    modport slave  (input Rx_data, input Rx_soc, input Rx_clav, output Rx_en);

endinterface

// File: rtl/utopia_cell_ram.sv
// Simple dual-port cell buffer: one write port, registered read port (1-cycle latency).
module utopia_cell_ram
    import utopia_pkg::*;
#(
    parameter int unsigned DEPTH  = 212,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  utopia_byte_t      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output utopia_byte_t      rdata
);

    utopia_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register drives the bus directly, so it holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/utopia_phy_rx_source.sv
// PHY-side Utopia Level 1 Rx source: buffers complete 53-byte cells and
// delivers them to the ATM layer under Rx_en control.
module utopia_phy_rx_source
    import utopia_pkg::*;
#(
    parameter int unsigned NCELLS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  utopia_byte_t          cell_in_data,
    input  logic                  cell_in_sop,
    input  logic                  cell_in_valid,
    output logic                  cell_in_ready,
    utopia_phy_rx_source_if.master rx,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned SLOT_W = $clog2(NCELLS);
    localparam int unsigned CNT_W  = SLOT_W + 1;
    localparam int unsigned DEPTH  = NCELLS * CELL_BYTES;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [SLOT_W-1:0] wr_slot;
    logic [SLOT_W-1:0] rd_slot;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [CNT_W-1:0]  stored;
    logic [CNT_W-1:0]  stored_nxt;
    logic              in_flight;
    logic              in_flight_nxt;
    logic [0:0]        state;
    logic              clav;
    logic              soc;

    logic              accept;
    logic              we;
    logic [IDX_W-1:0]  w_idx;
    logic              commit;
    logic              drop_evt;
    logic              re;
    logic [IDX_W-1:0]  r_idx;
    logic              start;
    logic              rel;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    utopia_byte_t      ram_q;

    assign cell_in_ready = stored < CNT_W'(NCELLS);
    assign accept        = cell_in_valid && cell_in_ready;

    always_comb begin
        we       = 1'b0;
        w_idx    = wr_idx;
        commit   = 1'b0;
        drop_evt = 1'b0;
        if (accept) begin
            if (cell_in_sop) begin
                we       = 1'b1;
                w_idx    = '0;
                drop_evt = (wr_idx != '0);
            end else if (wr_idx == '0) begin
                drop_evt = 1'b1;
            end else begin
                we     = 1'b1;
                commit = (wr_idx == LAST_IDX);
            end
        end
    end

    always_comb begin
        re    = 1'b0;
        r_idx = rd_idx;
        start = 1'b0;
        rel   = 1'b0;
        if (!rx.Rx_en) begin
            case (state)
                ST_IDLE: begin
                    if (clav) begin
                        re    = 1'b1;
                        r_idx = '0;
                        start = 1'b1;
                    end
                end
                ST_XFER: begin
                    re  = 1'b1;
                    rel = (rd_idx == LAST_IDX);
                end
                default: ;
            endcase
        end
    end

    // Commit and release in one cycle cancel out.
    assign stored_nxt    = stored + CNT_W'(commit) - CNT_W'(rel);
    assign in_flight_nxt = start ? 1'b1 : (rel ? 1'b0 : in_flight);

    assign waddr = ADDR_W'(32'(wr_slot) * CELL_BYTES + 32'(w_idx));
    assign raddr = ADDR_W'(32'(rd_slot) * CELL_BYTES + 32'(r_idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_slot   <= '0;
            wr_idx    <= '0;
            drop_cnt  <= '0;
        end else begin
            if (accept) begin
                if (cell_in_sop) begin
                    wr_idx <= IDX_W'(1);
                end else if (wr_idx != '0) begin
                    if (commit) begin
                        wr_idx  <= '0;
                        wr_slot <= wr_slot + 1'b1;
                    end else begin
                        wr_idx <= wr_idx + 1'b1;
                    end
                end
            end
            if (drop_evt && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_slot   <= '0;
            rd_idx    <= '0;
            stored    <= '0;
            in_flight <= 1'b0;
            clav      <= 1'b0;
            soc       <= 1'b0;
        end else begin
            soc <= start;
            if (start) begin
                rd_idx <= IDX_W'(1);
                state  <= ST_XFER;
            end else if (re) begin
                if (rel) begin
                    rd_idx  <= '0;
                    rd_slot <= rd_slot + 1'b1;
                    state   <= ST_IDLE;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
            stored    <= stored_nxt;
            in_flight <= in_flight_nxt;
            clav      <= (stored_nxt - CNT_W'(in_flight_nxt)) != '0;
        end
    end

    utopia_cell_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (cell_in_data),
        .re    (re),
        .raddr (raddr),
        .rdata (ram_q)
    );

    assign rx.Rx_data = ram_q;
    assign rx.Rx_soc  = soc;
    assign rx.Rx_clav = clav;

endmodule

// File: tb/tb_utopia_phy_rx_source.sv
// Self-checking bench for utopia_phy_rx_source against a cell-queue reference model.
module tb_utopia_phy_rx_source;
    import utopia_pkg::*;

    localparam int unsigned NCELLS = 4;

    logic         clk = 1'b0;
    logic         rst;
    utopia_byte_t cell_in_data;
    logic         cell_in_sop;
    logic         cell_in_valid;
    logic         cell_in_ready;
    logic [15:0]  drop_cnt;

    utopia_phy_rx_source_if rx();

    utopia_phy_rx_source #(.NCELLS(NCELLS)) dut (
        .clk           (clk),
        .rst           (rst),
        .cell_in_data  (cell_in_data),
        .cell_in_sop   (cell_in_sop),
        .cell_in_valid (cell_in_valid),
        .cell_in_ready (cell_in_ready),
        .rx            (rx),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: committed cells as a flat byte queue, front cell first.
    byte unsigned m_cells[$];
    int           m_ncells;
    bit           m_xfer;
    int           m_pos;
    byte unsigned m_part[$];
    int           m_drop;
    byte unsigned m_data;
    bit           m_soc;

    byte unsigned src_q[$];
    bit           src_sop[$];

    function automatic bit m_ready();
        return m_ncells < int'(NCELLS);
    endfunction

    function automatic bit m_clav();
        return (m_ncells - (m_xfer ? 1 : 0)) != 0;
    endfunction

    task automatic model_reset();
        m_cells.delete();
        m_part.delete();
        src_q.delete();
        src_sop.delete();
        m_ncells = 0;
        m_xfer   = 1'b0;
        m_pos    = 0;
        m_drop   = 0;
        m_data   = 8'h00;
        m_soc    = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst           = 1'b1;
        cell_in_valid = 1'b0;
        cell_in_sop   = 1'b0;
        cell_in_data  = 8'h00;
        rx.Rx_en      = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic push_cell(input byte unsigned base, input int len, input bit with_sop);
        for (int i = 0; i < len; i++) begin
            src_q.push_back(8'(int'(base) + i));
            src_sop.push_back(with_sop && (i == 0));
        end
    endtask

    // One clock: drive inputs, advance the model by the cell rules, sample #1 after the edge.
    task automatic cycle(input bit valid, input bit en_n);
        bit v;
        bit acc;
        bit clav_now;
        v        = valid && (src_q.size() > 0);
        acc      = v && m_ready();
        clav_now = m_clav();
        cell_in_valid = v;
        cell_in_sop   = v ? src_sop[0] : 1'b0;
        cell_in_data  = v ? src_q[0] : 8'h00;
        rx.Rx_en      = en_n;
        m_soc = 1'b0;
        if (!en_n) begin
            if (!m_xfer && clav_now) begin
                m_xfer = 1'b1;
                m_pos  = 0;
                m_soc  = 1'b1;
            end
            if (m_xfer) begin
                m_data = m_cells[m_pos];
                m_pos++;
                if (m_pos == int'(CELL_BYTES)) begin
                    repeat (CELL_BYTES) void'(m_cells.pop_front());
                    m_ncells--;
                    m_xfer = 1'b0;
                end
            end
        end
        if (acc) begin
            if (src_sop[0]) begin
                if (m_part.size() != 0 && m_drop < 65535) m_drop++;
                m_part.delete();
                m_part.push_back(src_q[0]);
            end else if (m_part.size() == 0) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                m_part.push_back(src_q[0]);
                if (m_part.size() == CELL_BYTES) begin
                    foreach (m_part[i]) m_cells.push_back(m_part[i]);
                    m_ncells++;
                    m_part.delete();
                end
            end
            void'(src_q.pop_front());
            void'(src_sop.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset(3);
        compared++; if (rx.Rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_data got=%h want=00", rx.Rx_data); end
        compared++; if (rx.Rx_soc !== 1'b0) begin mismatched++; $display("FAIL reset_soc got=%b want=0", rx.Rx_soc); end
        compared++; if (rx.Rx_clav !== 1'b0) begin mismatched++; $display("FAIL reset_clav got=%b want=0", rx.Rx_clav); end
        compared++; if (drop_cnt !== 16'h0000) begin mismatched++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
        compared++; if (cell_in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready got=%b want=1", cell_in_ready); end
    endtask

    task automatic test_single_cell();
        push_cell(8'h00, CELL_BYTES, 1'b1);
        while (src_q.size() > 0) cycle(1'b1, 1'b1);
        compared++; if (rx.Rx_clav !== 1'b1) begin mismatched++; $display("FAIL single_clav_set got=%b want=1", rx.Rx_clav); end
        for (int i = 0; i < int'(CELL_BYTES); i++) begin
            cycle(1'b0, 1'b0);
            compared++; if (rx.Rx_data !== 8'(i)) begin mismatched++; $display("FAIL single_data[%0d] got=%h want=%h", i, rx.Rx_data, 8'(i)); end
            compared++; if (rx.Rx_soc !== (i == 0)) begin mismatched++; $display("FAIL single_soc[%0d] got=%b want=%b", i, rx.Rx_soc, i == 0); end
        end
        compared++; if (rx.Rx_clav !== 1'b0) begin mismatched++; $display("FAIL single_clav_clr got=%b want=0", rx.Rx_clav); end
        cycle(1'b0, 1'b0);
        compared++; if (rx.Rx_data !== 8'h34) begin mismatched++; $display("FAIL single_hold got=%h want=34", rx.Rx_data); end
    endtask

    task automatic test_pause();
        push_cell(8'h00, CELL_BYTES, 1'b1);
        while (src_q.size() > 0) cycle(1'b1, 1'b1);
        for (int k = 0; k < 58; k++) begin
            cycle(1'b0, (k >= 11 && k < 16));
            compared++; if (rx.Rx_data !== m_data) begin mismatched++; $display("FAIL pause_data[%0d] got=%h want=%h", k, rx.Rx_data, m_data); end
            if (k >= 11 && k < 16) begin
                compared++; if (rx.Rx_data !== 8'h0A) begin mismatched++; $display("FAIL pause_hold[%0d] got=%h want=0a", k, rx.Rx_data); end
            end
            if (k == 16) begin
                compared++; if (rx.Rx_data !== 8'h0B) begin mismatched++; $display("FAIL pause_resume got=%h want=0b", rx.Rx_data); end
            end
        end
        compared++; if (rx.Rx_data !== 8'h34) begin mismatched++; $display("FAIL pause_last got=%h want=34", rx.Rx_data); end
        compared++; if (rx.Rx_clav !== 1'b0) begin mismatched++; $display("FAIL pause_clav got=%b want=0", rx.Rx_clav); end
    endtask

    task automatic test_full();
        int guard;
        do_reset(2);
        for (int b = 0; b <= int'(NCELLS); b++) push_cell(8'(b * 40 + 1), CELL_BYTES, 1'b1);
        repeat (NCELLS * CELL_BYTES) cycle(1'b1, 1'b1);
        compared++; if (cell_in_ready !== 1'b0) begin mismatched++; $display("FAIL full_ready got=%b want=0", cell_in_ready); end
        compared++; if (rx.Rx_clav !== 1'b1) begin mismatched++; $display("FAIL full_clav got=%b want=1", rx.Rx_clav); end
        repeat (20) cycle(1'b1, 1'b1);
        compared++; if (cell_in_ready !== 1'b0) begin mismatched++; $display("FAIL full_stall got=%b want=0", cell_in_ready); end
        for (int i = 0; i < int'(CELL_BYTES); i++) begin
            cycle(1'b0, 1'b0);
            compared++; if (rx.Rx_data !== m_data) begin mismatched++; $display("FAIL full_rd1[%0d] got=%h want=%h", i, rx.Rx_data, m_data); end
        end
        compared++; if (cell_in_ready !== 1'b1) begin mismatched++; $display("FAIL full_freed got=%b want=1", cell_in_ready); end
        guard = 0;
        while (src_q.size() > 0 && guard < 200) begin cycle(1'b1, 1'b1); guard++; end
        compared++; if (src_q.size() != 0) begin mismatched++; $display("FAIL full_fill_timeout left=%0d want=0", src_q.size()); end
        compared++; if (cell_in_ready !== m_ready()) begin mismatched++; $display("FAIL full_refill got=%b want=%b", cell_in_ready, m_ready()); end
        guard = 0;
        while ((m_ncells > 0) && guard < 400) begin
            cycle(1'b0, 1'b0);
            guard++;
            compared++; if (rx.Rx_data !== m_data || rx.Rx_soc !== m_soc) begin
                mismatched++; $display("FAIL full_drain[%0d] got=%h/%b want=%h/%b", guard, rx.Rx_data, rx.Rx_soc, m_data, m_soc);
            end
        end
        compared++; if (rx.Rx_clav !== 1'b0) begin mismatched++; $display("FAIL full_empty_clav got=%b want=0", rx.Rx_clav); end
    endtask

    task automatic test_runt_orphan();
        int socs;
        do_reset(2);
        push_cell(8'h80, 20, 1'b1);
        push_cell(8'hA0, CELL_BYTES, 1'b1);
        push_cell(8'hF0, 3, 1'b0);
        repeat (21) cycle(1'b1, 1'b1);
        compared++; if (drop_cnt !== 16'd1) begin mismatched++; $display("FAIL runt_drop got=%0d want=1", drop_cnt); end
        while (src_q.size() > 0) cycle(1'b1, 1'b1);
        compared++; if (drop_cnt !== 16'd4) begin mismatched++; $display("FAIL orphan_drop got=%0d want=4", drop_cnt); end
        socs = 0;
        for (int k = 0; k < 70; k++) begin
            cycle(1'b0, 1'b0);
            if (rx.Rx_soc === 1'b1) socs++;
            if (k == 0) begin
                compared++; if (rx.Rx_data !== 8'hA0) begin mismatched++; $display("FAIL runt_first got=%h want=a0", rx.Rx_data); end
            end
        end
        compared++; if (socs != 1) begin mismatched++; $display("FAIL runt_cells got=%0d want=1", socs); end
        compared++; if (rx.Rx_data !== 8'hD4) begin mismatched++; $display("FAIL runt_last got=%h want=d4", rx.Rx_data); end
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        push_cell(8'h10, CELL_BYTES, 1'b1);
        push_cell(8'h60, CELL_BYTES, 1'b1);
        while (src_q.size() > 0) cycle(1'b1, 1'b1);
        for (int k = 0; k < 2 * int'(CELL_BYTES) + 4; k++) begin
            cycle(1'b0, 1'b0);
            compared++; if (rx.Rx_data !== m_data || rx.Rx_soc !== m_soc || rx.Rx_clav !== m_clav()) begin
                mismatched++; $display("FAIL b2b[%0d] got=%h/%b/%b want=%h/%b/%b", k, rx.Rx_data, rx.Rx_soc, rx.Rx_clav, m_data, m_soc, m_clav());
            end
            if (k < int'(CELL_BYTES)) begin
                compared++; if (rx.Rx_clav !== 1'b1) begin mismatched++; $display("FAIL b2b_clav[%0d] got=%b want=1", k, rx.Rx_clav); end
            end
            if (k == int'(CELL_BYTES)) begin
                compared++; if (rx.Rx_soc !== 1'b1 || rx.Rx_data !== 8'h60) begin
                    mismatched++; $display("FAIL b2b_soc2 got=%b/%h want=1/60", rx.Rx_soc, rx.Rx_data);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        push_cell(8'h20, CELL_BYTES, 1'b1);
        while (src_q.size() > 0) cycle(1'b1, 1'b1);
        repeat (31) cycle(1'b0, 1'b0);
        compared++; if (rx.Rx_data !== 8'h3E) begin mismatched++; $display("FAIL mid_byte30 got=%h want=3e", rx.Rx_data); end
        do_reset(2);
        compared++; if (rx.Rx_data !== 8'h00 || rx.Rx_soc !== 1'b0) begin mismatched++; $display("FAIL mid_out got=%h/%b want=00/0", rx.Rx_data, rx.Rx_soc); end
        compared++; if (rx.Rx_clav !== 1'b0) begin mismatched++; $display("FAIL mid_clav got=%b want=0", rx.Rx_clav); end
        compared++; if (cell_in_ready !== 1'b1) begin mismatched++; $display("FAIL mid_ready got=%b want=1", cell_in_ready); end
        push_cell(8'h30, CELL_BYTES, 1'b1);
        while (src_q.size() > 0) cycle(1'b1, 1'b1);
        for (int i = 0; i < int'(CELL_BYTES); i++) begin
            cycle(1'b0, 1'b0);
            compared++; if (rx.Rx_data !== 8'(8'h30 + i) || rx.Rx_soc !== (i == 0)) begin
                mismatched++; $display("FAIL mid_rd[%0d] got=%h/%b want=%h/%b", i, rx.Rx_data, rx.Rx_soc, 8'(8'h30 + i), i == 0);
            end
        end
    endtask

    task automatic test_random();
        int guard;
        int kind;
        do_reset(2);
        for (int c = 0; c < 24; c++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7) push_cell(8'($urandom), CELL_BYTES, 1'b1);
            else if (kind < 9) push_cell(8'($urandom), $urandom_range(1, 52), 1'b1);
            else push_cell(8'($urandom), $urandom_range(1, 3), 1'b0);
        end
        push_cell(8'h5A, CELL_BYTES, 1'b1);
        guard = 0;
        while ((src_q.size() > 0 || m_ncells > 0) && guard < 8000) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 2);
            guard++;
            compared++; if (rx.Rx_data !== m_data || rx.Rx_soc !== m_soc) begin
                mismatched++; $display("FAIL rand_data[%0d] got=%h/%b want=%h/%b", guard, rx.Rx_data, rx.Rx_soc, m_data, m_soc);
            end
            compared++; if (rx.Rx_clav !== m_clav() || cell_in_ready !== m_ready()) begin
                mismatched++; $display("FAIL rand_flags[%0d] got=%b/%b want=%b/%b", guard, rx.Rx_clav, cell_in_ready, m_clav(), m_ready());
            end
            compared++; if (drop_cnt !== 16'(m_drop)) begin
                mismatched++; $display("FAIL rand_drop[%0d] got=%0d want=%0d", guard, drop_cnt, m_drop);
            end
        end
        compared++; if (guard >= 8000) begin mismatched++; $display("FAIL rand_timeout got=%0d want<8000", guard); end
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_pause();
        test_full();
        test_runt_orphan();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
